// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: recovers the VGA pixel grid from sync/RGB and reports per-frame sprite statistics
module vga_frame_monitor #(
    parameter int          H_ACTIVE    = 1600,
    parameter int          H_TOTAL     = 2160,
    parameter int          H_BACK      = 304,
    parameter int          V_ACTIVE    = 1200,
    parameter int          V_TOTAL     = 1250,
    parameter int          V_BACK      = 46,
    parameter logic        SYNC_POL    = 1'b1,
    parameter logic [11:0] BG_COLOR    = 12'h000,
    parameter int          LOCK_FRAMES = 2
) (
    input  logic        clock_162,
    input  logic        rst,
    input  logic        HSYNC,
    input  logic        VSYNC,
    input  logic [3:0]  RED,
    input  logic [3:0]  GREEN,
    input  logic [3:0]  BLUE,
    output logic        locked,
    output logic        frame_valid,
    output logic        sprite_seen,
    output logic [10:0] min_row,
    output logic [10:0] max_row,
    output logic [11:0] min_col,
    output logic [11:0] max_col,
    output logic [10:0] center_row,
    output logic [11:0] center_col,
    output logic [20:0] pixel_count,
    output logic [7:0]  error_count
);
    localparam int HW  = $clog2(2 * H_TOTAL + 1);
    localparam int VW  = $clog2(V_TOTAL + 1);
    localparam int VW1 = VW + 1;
    localparam int GW  = $clog2(LOCK_FRAMES + 1);
    localparam logic [HW-1:0]  H_TMO   = HW'(2 * H_TOTAL);
    localparam logic [HW-1:0]  H_PER   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_LO    = HW'(H_BACK);
    localparam logic [HW-1:0]  H_HI    = HW'(H_BACK + H_ACTIVE);
    localparam logic [VW-1:0]  V_LO    = VW'(V_BACK);
    localparam logic [VW-1:0]  V_HI    = VW'(V_BACK + V_ACTIVE);
    localparam logic [VW-1:0]  V_MAX   = VW'(V_TOTAL);
    localparam logic [VW-1:0]  V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW1-1:0] V_FRAME = VW1'(V_TOTAL);
    localparam logic [GW-1:0]  G_LAST  = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {HUNT, TRAIN, LOCKED} state_t;

    logic          r_hs, r_hs_d, r_vs, r_vs_d;
    logic [11:0]   r_rgb;
    logic [HW-1:0] r_h, r_per;
    logic [VW-1:0] r_v;
    logic [10:0]   r_min_row, r_max_row;
    logic [11:0]   r_min_col, r_max_col;
    logic [20:0]   r_cnt;
    state_t        r_state;
    logic [GW-1:0] r_good;

    logic           w_hs_as, w_hs_de, w_vs_de, w_vis, w_lit, w_fail, w_seen;
    logic [HW-1:0]  w_h;
    logic [VW1-1:0] w_vsum;
    logic [10:0]    w_row;
    logic [11:0]    w_col, w_rsum;
    logic [12:0]    w_csum;

    assign w_hs_as = (r_hs == SYNC_POL) && (r_hs_d != SYNC_POL);
    assign w_hs_de = (r_hs != SYNC_POL) && (r_hs_d == SYNC_POL);
    assign w_vs_de = (r_vs != SYNC_POL) && (r_vs_d == SYNC_POL);
    // h_cnt is zero on the very cycle the deassert edge is seen, so it pairs with r_rgb of that cycle
    assign w_h     = w_hs_de ? '0 : (r_h == H_TMO ? r_h : r_h + 1'b1);
    assign w_vsum  = {1'b0, r_v} + {{VW{1'b0}}, w_hs_as};
    assign w_vis   = (w_h >= H_LO) && (w_h < H_HI) && (r_v >= V_LO) && (r_v < V_HI);
    assign w_lit   = w_vis && (r_rgb != BG_COLOR);
    assign w_col   = 12'(w_h - H_LO);
    assign w_row   = 11'(r_v - V_LO);
    // An edge coinciding with the closing VSYNC edge still belongs to the closing frame's count
    assign w_fail  = (w_hs_as && r_per != H_PER) ||
                     (w_hs_as && !w_vs_de && r_v >= V_LAST) ||
                     (w_vs_de && w_vsum != V_FRAME) ||
                     (w_h == H_TMO);
    assign w_seen  = r_cnt != '0;
    assign w_rsum  = {1'b0, r_min_row} + {1'b0, r_max_row};
    assign w_csum  = {1'b0, r_min_col} + {1'b0, r_max_col};

    // Register inputs once plus a delayed sync copy for edge detection
    always_ff @(posedge clock_162) begin
        if (rst) begin
            r_hs   <= !SYNC_POL;
            r_hs_d <= !SYNC_POL;
            r_vs   <= !SYNC_POL;
            r_vs_d <= !SYNC_POL;
            r_rgb  <= '0;
        end else begin
            r_hs   <= HSYNC;
            r_hs_d <= r_hs;
            r_vs   <= VSYNC;
            r_vs_d <= r_vs;
            r_rgb  <= {RED, GREEN, BLUE};
        end
    end

    // Horizontal position, line period and line-in-frame counters, saturating to stay bounded
    always_ff @(posedge clock_162) begin
        if (rst) begin
            r_h   <= '0;
            r_per <= '0;
            r_v   <= '0;
        end else begin
            r_h   <= w_h;
            r_per <= w_hs_as ? '0 : (r_per == H_TMO ? r_per : r_per + 1'b1);
            r_v   <= w_vs_de ? '0 : ((w_hs_as && r_v != V_MAX) ? r_v + 1'b1 : r_v);
        end
    end

    // Per-frame bounding box and lit-pixel accumulators, restarted at each frame boundary
    always_ff @(posedge clock_162) begin
        if (rst || w_vs_de) begin
            r_min_row <= '1;
            r_max_row <= '0;
            r_min_col <= '1;
            r_max_col <= '0;
            r_cnt     <= '0;
        end else if (w_lit) begin
            r_min_row <= w_row < r_min_row ? w_row : r_min_row;
            r_max_row <= w_row > r_max_row ? w_row : r_max_row;
            r_min_col <= w_col < r_min_col ? w_col : r_min_col;
            r_max_col <= w_col > r_max_col ? w_col : r_max_col;
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    // Lock FSM with registered results; only frames spent entirely in LOCKED are reported
    always_ff @(posedge clock_162) begin
        if (rst) begin
            r_state     <= HUNT;
            r_good      <= '0;
            locked      <= 1'b0;
            frame_valid <= 1'b0;
            sprite_seen <= 1'b0;
            min_row     <= '0;
            max_row     <= '0;
            min_col     <= '0;
            max_col     <= '0;
            center_row  <= '0;
            center_col  <= '0;
            pixel_count <= '0;
            error_count <= '0;
        end else begin
            frame_valid <= 1'b0;
            case (r_state)
                HUNT: if (w_vs_de) begin
                    r_state <= TRAIN;
                    r_good  <= '0;
                end
                TRAIN: if (w_fail) begin
                    r_state <= HUNT;
                end else if (w_vs_de) begin
                    if (r_good == G_LAST) begin
                        r_state <= LOCKED;
                        locked  <= 1'b1;
                    end else begin
                        r_good <= r_good + 1'b1;
                    end
                end
                LOCKED: if (w_fail) begin
                    r_state     <= HUNT;
                    locked      <= 1'b0;
                    error_count <= error_count + {7'd0, error_count != 8'hFF};
                end else if (w_vs_de) begin
                    frame_valid <= 1'b1;
                    sprite_seen <= w_seen;
                    min_row     <= w_seen ? r_min_row : '0;
                    max_row     <= w_seen ? r_max_row : '0;
                    min_col     <= w_seen ? r_min_col : '0;
                    max_col     <= w_seen ? r_max_col : '0;
                    center_row  <= w_seen ? w_rsum[11:1] : '0;
                    center_col  <= w_seen ? w_csum[12:1] : '0;
                    pixel_count <= r_cnt;
                end
                default: r_state <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: directed tests with a behavioural VGA generator on a reduced timing grid
module tb_vga_frame_monitor;
    localparam int HA = 16, HT = 24, HB = 4, VA = 12, VT = 16, VB = 2, HS_W = 2, VS_W = 1;

    logic        clk = 1'b0, rst = 1'b1, hs = 1'b0, vs = 1'b0;
    logic [3:0]  r = '0, g = '0, b = '0;
    logic        locked, frame_valid, sprite_seen;
    logic [10:0] min_row, max_row, center_row;
    logic [11:0] min_col, max_col, center_col;
    logic [20:0] pixel_count;
    logic [7:0]  error_count;

    int checks = 0, errors = 0, cyc = 0;
    int gen_en = 0, pat = 0, stretch_req = 0, edge_cyc = -1;

    vga_frame_monitor #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_BACK(HB), .V_ACTIVE(VA), .V_TOTAL(VT), .V_BACK(VB),
        .SYNC_POL(1'b1), .BG_COLOR(12'h000), .LOCK_FRAMES(2)
    ) dut (
        .clock_162(clk), .rst(rst), .HSYNC(hs), .VSYNC(vs), .RED(r), .GREEN(g), .BLUE(b),
        .locked(locked), .frame_valid(frame_valid), .sprite_seen(sprite_seen),
        .min_row(min_row), .max_row(max_row), .min_col(min_col), .max_col(max_col),
        .center_row(center_row), .center_col(center_col), .pixel_count(pixel_count),
        .error_count(error_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural driver: sync pulses first, then back porch, active area, front porch
    initial begin
        int gp, gy, len, h, col, row;
        bit vis, lit, was_str;
        gp = 0; gy = 0; len = HT; was_str = 0;
        forever begin
            @(negedge clk);
            if (gen_en == 0) begin
                hs = 0; vs = 0; {r, g, b} = 12'h000; gp = 0; gy = 0; len = HT;
            end else begin
                hs = gp < HS_W;
                vs = gy < VS_W;
                if (gp == 0 && was_str) begin edge_cyc = cyc; was_str = 0; end
                h   = gp - HS_W;
                col = h - HB;
                row = gy - VS_W - VB;
                vis = col >= 0 && col < HA && row >= 0 && row < VA;
                lit = (pat == 1 && vis && row >= 5 && row <= 7 && col >= 10 && col <= 12) ||
                      (pat == 2 && ((vis && ((row == 0 && col == 0) || (row == 11 && col == 15))) || (h == 2 && row == 4)));
                {r, g, b} = lit ? 12'hF00 : 12'h000;
                gp++;
                if (gp == len) begin
                    gp = 0;
                    gy = (gy + 1) % VT;
                    was_str = len != HT;
                    len = stretch_req ? HT + 1 : HT;
                    stretch_req = 0;
                end
            end
        end
    end

    task automatic wait_fv(input int lim, output int n);
        int i = 0;
        n = -1;
        while (n < 0 && i < lim) begin
            @(negedge clk);
            i++;
            if (frame_valid === 1'b1) n = i;
        end
    endtask

    task automatic wait_locked(input logic lvl, input int lim, output int n, output int fv_seen);
        int i = 0;
        n = -1;
        fv_seen = 0;
        while (n < 0 && i < lim) begin
            @(negedge clk);
            i++;
            if (frame_valid === 1'b1) fv_seen++;
            if (locked === lvl) n = i;
        end
    endtask

    task automatic test_reset;
        int fv = 0, lk = 0;
        rst = 1;
        repeat (5) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset locked: got %b want 0", locked); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset frame_valid: got %b want 0", frame_valid); end
        checks++; if ({sprite_seen, min_row, max_row, min_col, max_col, center_row, center_col, pixel_count, error_count} !== '0) begin
            errors++; $display("FAIL reset outputs: got %h want 0", {sprite_seen, min_row, max_row, min_col, max_col, center_row, center_col, pixel_count, error_count});
        end
        repeat (100) begin
            @(negedge clk);
            if (frame_valid === 1'b1) fv++;
            if (locked === 1'b1) lk++;
        end
        checks++; if (fv !== 0) begin errors++; $display("FAIL idle frame_valid pulses: got %0d want 0", fv); end
        checks++; if (lk !== 0) begin errors++; $display("FAIL idle locked cycles: got %0d want 0", lk); end
    endtask

    task automatic test_lock;
        int s, n, fv;
        s = cyc;
        pat = 0;
        gen_en = 1;
        wait_locked(1'b1, 1200, n, fv);
        checks++; if (n < 0 || cyc - s < 790 || cyc - s > 800) begin errors++; $display("FAIL lock time: got %0d cycles want 790..800", cyc - s); end
        checks++; if (fv !== 0) begin errors++; $display("FAIL frame_valid before lock: got %0d want 0", fv); end
        wait_fv(600, n);
        checks++; if (n < 0 || cyc - s < 1174 || cyc - s > 1184) begin errors++; $display("FAIL first report time: got %0d cycles want 1174..1184", cyc - s); end
        checks++; if (sprite_seen !== 1'b0) begin errors++; $display("FAIL empty sprite_seen: got %b want 0", sprite_seen); end
        checks++; if (pixel_count !== 21'd0) begin errors++; $display("FAIL empty pixel_count: got %0d want 0", pixel_count); end
        checks++; if ({min_row, max_row, min_col, max_col, center_row, center_col} !== '0) begin
            errors++; $display("FAIL empty bbox: got %h want 0", {min_row, max_row, min_col, max_col, center_row, center_col});
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL locked at report: got %b want 1", locked); end
    endtask

    task automatic test_sprite;
        int n;
        pat = 1;
        wait_fv(800, n);
        checks++; if (n < 380 || n > 386) begin errors++; $display("FAIL sprite report interval: got %0d want 380..386", n); end
        checks++; if (sprite_seen !== 1'b1) begin errors++; $display("FAIL sprite sprite_seen: got %b want 1", sprite_seen); end
        checks++; if (min_row !== 11'd5) begin errors++; $display("FAIL sprite min_row: got %0d want 5", min_row); end
        checks++; if (max_row !== 11'd7) begin errors++; $display("FAIL sprite max_row: got %0d want 7", max_row); end
        checks++; if (min_col !== 12'd10) begin errors++; $display("FAIL sprite min_col: got %0d want 10", min_col); end
        checks++; if (max_col !== 12'd12) begin errors++; $display("FAIL sprite max_col: got %0d want 12", max_col); end
        checks++; if (center_row !== 11'd6) begin errors++; $display("FAIL sprite center_row: got %0d want 6", center_row); end
        checks++; if (center_col !== 12'd11) begin errors++; $display("FAIL sprite center_col: got %0d want 11", center_col); end
        checks++; if (pixel_count !== 21'd9) begin errors++; $display("FAIL sprite pixel_count: got %0d want 9", pixel_count); end
        @(negedge clk);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL frame_valid pulse width: got %b want 0", frame_valid); end
    endtask

    task automatic test_corners;
        int n;
        pat = 2;
        wait_fv(800, n);
        repeat (20) @(negedge clk);
        checks++; if (n < 0) begin errors++; $display("FAIL corners report: got timeout want frame_valid"); end
        checks++; if ({min_row, max_row} !== {11'd0, 11'd11}) begin errors++; $display("FAIL corners rows: got %0d..%0d want 0..11", min_row, max_row); end
        checks++; if ({min_col, max_col} !== {12'd0, 12'd15}) begin errors++; $display("FAIL corners cols: got %0d..%0d want 0..15", min_col, max_col); end
        checks++; if (center_row !== 11'd5) begin errors++; $display("FAIL corners center_row: got %0d want 5", center_row); end
        checks++; if (center_col !== 12'd7) begin errors++; $display("FAIL corners center_col: got %0d want 7", center_col); end
        checks++; if (pixel_count !== 21'd2) begin errors++; $display("FAIL corners pixel_count: got %0d want 2", pixel_count); end
        checks++; if (sprite_seen !== 1'b1) begin errors++; $display("FAIL corners sprite_seen: got %b want 1", sprite_seen); end
    endtask

    task automatic test_stretch;
        int n, fv;
        wait_fv(800, n);
        pat = 0;
        stretch_req = 1;
        wait_locked(1'b0, 400, n, fv);
        checks++; if (n < 0 || cyc - edge_cyc < 1 || cyc - edge_cyc > 2) begin
            errors++; $display("FAIL stretch unlock latency: got %0d cycles want 1..2", cyc - edge_cyc);
        end
        checks++; if (error_count !== 8'd1) begin errors++; $display("FAIL stretch error_count: got %0d want 1", error_count); end
        wait_locked(1'b1, 1600, n, fv);
        checks++; if (n < 0) begin errors++; $display("FAIL stretch relock: got timeout want locked"); end
        checks++; if (fv !== 0) begin errors++; $display("FAIL stretch frame_valid while unlocked: got %0d want 0", fv); end
        wait_fv(600, n);
        checks++; if (n < 0 || pixel_count !== 21'd0 || sprite_seen !== 1'b0) begin
            errors++; $display("FAIL relock report: got n=%0d count=%0d seen=%b want empty frame", n, pixel_count, sprite_seen);
        end
        checks++; if (error_count !== 8'd1) begin errors++; $display("FAIL relock error_count: got %0d want 1", error_count); end
    endtask

    task automatic test_mid_reset;
        int s, n, fv;
        repeat (100) @(negedge clk);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pre-reset locked: got %b want 1", locked); end
        rst = 1;
        @(negedge clk);
        checks++; if ({locked, frame_valid, sprite_seen, min_row, max_row, min_col, max_col, center_row, center_col, pixel_count, error_count} !== '0) begin
            errors++; $display("FAIL mid reset outputs: got %h want 0", {locked, frame_valid, sprite_seen, min_row, max_row, min_col, max_col, center_row, center_col, pixel_count, error_count});
        end
        rst = 0;
        s = cyc;
        wait_locked(1'b1, 1400, n, fv);
        checks++; if (n < 0 || cyc - s < 768 || cyc - s > 1160) begin errors++; $display("FAIL relock after reset: got %0d cycles want 768..1160", cyc - s); end
        checks++; if (fv !== 0) begin errors++; $display("FAIL frame_valid before relock: got %0d want 0", fv); end
        checks++; if (error_count !== 8'd0) begin errors++; $display("FAIL error_count after reset: got %0d want 0", error_count); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_sprite();
        test_corners();
        test_stretch();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_frame_monitor.md
Name: vga_frame_monitor

Overview:
Receive-side counterpart to the VGA driver. It decodes the HSYNC/VSYNC/RGB stream the driver produces and recovers the pixel grid. Each frame it measures the bounding box, centre and lit-pixel count of non-background pixels. It sits on the 162 MHz domain and is used for on-board self-test: the reported centre is compared against the sprite_row/sprite_col fed to the driver.

Parameters:
H_ACTIVE, 1600, visible pixels per line
H_TOTAL, 2160, clock cycles per line (HSYNC assert edge to next HSYNC assert edge)
H_BACK, 304, cycles from HSYNC deassert to first visible pixel
V_ACTIVE, 1200, visible lines per frame
V_TOTAL, 1250, lines per frame (HSYNC assert edges between VSYNC deassert edges)
V_BACK, 46, lines from VSYNC deassert to first visible line
SYNC_POL, 1, active level of HSYNC/VSYNC
BG_COLOR, 12'h000, {R,G,B} value treated as unlit
LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
clock_162  in  1  pixel clock
rst  in  1  synchronous active-high reset
HSYNC  in  1  horizontal sync from driver
VSYNC  in  1  vertical sync from driver
RED, GREEN, BLUE  in  4 each  pixel colour
locked  out  1  timing lock achieved
frame_valid  out  1  one-cycle pulse; result outputs updated
sprite_seen  out  1  last reported frame contained at least one lit pixel
min_row, max_row  out  11  bounding-box rows
min_col, max_col  out  12  bounding-box columns
center_row  out  11  (min_row+max_row)>>1
center_col  out  12  (min_col+max_col)>>1
pixel_count  out  21  lit visible pixels in frame
error_count  out  8  timing violations while locked, saturating

Behaviour:
- Reset: every output is 0, FSM goes to HUNT, and all counters clear. Reset wins over every simultaneous event.
- Input capture: all inputs are registered once. Edges are detected between the registered value and its one-cycle-delayed copy.
- Horizontal counter: h_cnt is 0 on the cycle the registered HSYNC deassert edge is seen, then increments by 1 per cycle.
- Line period: measured from HSYNC assert edge to HSYNC assert edge.
- Vertical counter: v_cnt clears to 0 on a VSYNC deassert edge and increments on each HSYNC assert edge.
- Visible region: a pixel is visible when h_cnt is in [H_BACK, H_BACK+H_ACTIVE) and v_cnt is in [V_BACK, V_BACK+V_ACTIVE).
  - col = h_cnt-H_BACK; row = v_cnt-V_BACK.
  - A visible pixel is lit when {R,G,B} != BG_COLOR.
  - Lit pixels outside the visible region are ignored.
- FSM HUNT: wait for a VSYNC deassert edge, then go to TRAIN with good-frame count = 0.
- FSM TRAIN/LOCKED checks:
  - Each line period must equal H_TOTAL.
  - Each frame's HSYNC assert edge count must equal V_TOTAL.
  - h_cnt reaching 2*H_TOTAL with no HSYNC edge counts as a failure (timeout).
- FSM TRAIN:
  - On a VSYNC deassert edge with no failure in the frame, increment the good-frame count.
  - When the count reaches LOCK_FRAMES, go to LOCKED and assert locked the next cycle.
  - Any failure goes to HUNT.
- FSM LOCKED: any failure goes to HUNT.
  - locked deasserts on the cycle after the failing edge.
  - error_count increments, saturating at 255.
  - The current frame is discarded.
- Statistics: min/max/count accumulators reset at every VSYNC deassert edge.
  - Min accumulators reset to all-ones; max and count accumulators reset to 0.
  - They update on each lit visible pixel.
- Frame result: a frame is reportable only if the FSM was LOCKED for the whole frame, from VSYNC deassert edge to VSYNC deassert edge.
  - At the closing edge, latch the results and pulse frame_valid.
  - The latched outputs and frame_valid appear 2 cycles after VSYNC deasserts at the port.
  - Outputs hold until the next report.
- Empty frame: sprite_seen=0, and bbox, centres and pixel_count are 0.
- Centre arithmetic: sums are taken one bit wider, then truncated after the shift (floor).
- TRAIN->LOCKED frame: the transition frame is not reported, since it was not locked throughout.

Test Plan:
(bench uses H_ACTIVE=16, H_TOTAL=24, H_BACK=4, V_ACTIVE=12, V_TOTAL=16, V_BACK=2, LOCK_FRAMES=2, with a behavioural VGA generator)
1. Hold rst 5 cycles, then no sync activity -> all outputs 0, locked=0, no frame_valid.
2. Clean timing, all pixels 12'h000 -> locked rises after the 2nd complete frame. The first frame_valid comes at the end of the 3rd frame with sprite_seen=0 and pixel_count=0.
3. Lit pixels 12'hF00 at rows 5-7, cols 10-12 -> min_row=5, max_row=7, min_col=10, max_col=12, center=(6,11), pixel_count=9, sprite_seen=1.
4. Lit pixels at (0,0) and (11,15), plus a lit sample at h_cnt=2 (blanking) -> bbox rows 0..11, cols 0..15, center=(5,7), pixel_count=2.
5. While locked, stretch one line to 25 cycles -> locked=0 within 2 cycles of that HSYNC edge, error_count=1, no frame_valid for that frame. Relock after 2 good frames.
6. Assert rst mid-frame while locked -> next cycle all outputs 0 and error_count=0. After rst release, the full lock sequence repeats.
